// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_pkg: shared op encodings, FSM state enum and default widths
// for the memory access sequencer.
// Build option: MEM_ACCESS_VERIFY_EN adds the VERIFY state.
package mem_access_pkg;

  localparam int DW_DEF = 8;
  localparam int AW_DEF = 8;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STORE = 2'b01,
    OP_ADD   = 2'b10,
    OP_SWAP  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_WRITE  = 3'd2,
`ifdef MEM_ACCESS_VERIFY_EN
    ST_VERIFY = 3'd3,
`endif
    ST_RESP   = 3'd4
  } state_e;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: request/response handshake bundle between the execute
// stage (master) and the memory access sequencer (slave).
interface mem_access_ctrl_if #(
  parameter int DW = 8,
  parameter int AW = 8
);

  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mem_access_ctrl_wdata.sv
// mem_access_wdata: selects the RAM write data. ADD writes the wrapped sum of
// the old word and the addend; STORE/SWAP write the request data unchanged.
module mem_access_wdata
  import mem_access_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  op_e           op,
  input  logic [DW-1:0] old_data,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] wr_data
);

  // carry out of the adder is intentionally discarded
  always_comb begin
    wr_data = wdata;
    if (op == OP_ADD) begin
      wr_data = old_data + wdata;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences LOAD / STORE / ADD / SWAP requests onto a
// 256x8 RAM with combinational read and write-on-posedge when ram_rw=1.
// Build option: MEM_ACCESS_VERIFY_EN enables a read-back VERIFY cycle after
// every write and reports mismatches on rsp_err.
//
// state  | meaning
// IDLE   | ready for a request; latches op/addr/wdata on req_valid
// READ   | address driven, old word captured into old_q
// WRITE  | ram_rw high for one cycle with the selected write data
// VERIFY | read back the address and compare with the written value
// RESP   | response held until rsp_ready
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  mem_access_ctrl_if.slave   bus,
  output logic               ram_rw,
  output logic [AW-1:0]      ram_addr,
  output logic [DW-1:0]      ram_wdata,
  input  logic [DW-1:0]      ram_rdata,
  output logic               busy
);

  state_e        state;
  state_e        state_nx;
  op_e           op_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] old_q;
  logic          err_q;
  logic [DW-1:0] wr_data;
  logic          accept;
  op_e           req_op_e;

  assign req_op_e = op_e'(bus.req_op);
  assign accept   = (state == ST_IDLE) && bus.req_valid;

  mem_access_wdata #(.DW(DW)) u_wdata (
    .op       (op_q),
    .old_data (old_q),
    .wdata    (wdata_q),
    .wr_data  (wr_data)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          state_nx = (req_op_e == OP_STORE) ? ST_WRITE : ST_READ;
        end
      end
      ST_READ: begin
        state_nx = (op_q == OP_LOAD) ? ST_RESP : ST_WRITE;
      end
      ST_WRITE: begin
`ifdef MEM_ACCESS_VERIFY_EN
        state_nx = ST_VERIFY;
`else
        state_nx = ST_RESP;
`endif
      end
`ifdef MEM_ACCESS_VERIFY_EN
      ST_VERIFY: begin
        state_nx = ST_RESP;
      end
`endif
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_nx = ST_IDLE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // request capture and old-word capture
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= OP_LOAD;
      addr_q  <= '0;
      wdata_q <= '0;
      old_q   <= '0;
    end else begin
      if (accept) begin
        op_q    <= req_op_e;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (state == ST_READ) begin
        old_q <= ram_rdata;
      end
    end
  end

`ifdef MEM_ACCESS_VERIFY_EN
  logic [DW-1:0] written_q;

  // hold the written word and flag a read-back mismatch; a LOAD clears the flag
  always_ff @(posedge clk) begin
    if (rst) begin
      written_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (state == ST_WRITE) begin
        written_q <= wr_data;
      end
      if (state == ST_VERIFY) begin
        err_q <= (ram_rdata != written_q);
      end else if (accept && (req_op_e == OP_LOAD)) begin
        err_q <= 1'b0;
      end
    end
  end
`else
  assign err_q = 1'b0;
`endif

  // outputs; everything is forced low while rst is high so no write can slip
  // out in the reset cycle even if the state register still says WRITE
  always_comb begin
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_rdata = '0;
    bus.rsp_err   = 1'b0;
    ram_rw        = 1'b0;
    ram_addr      = '0;
    ram_wdata     = '0;
    busy          = 1'b0;
    if (!rst) begin
      busy = (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          bus.req_ready = 1'b1;
        end
        ST_READ: begin
          ram_addr = addr_q;
        end
        ST_WRITE: begin
          ram_rw    = 1'b1;
          ram_addr  = addr_q;
          ram_wdata = wr_data;
        end
`ifdef MEM_ACCESS_VERIFY_EN
        ST_VERIFY: begin
          ram_addr = addr_q;
        end
`endif
        ST_RESP: begin
          bus.rsp_valid = 1'b1;
          bus.rsp_rdata = (op_q == OP_STORE) ? '0 : old_q;
          bus.rsp_err   = err_q;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed request table against a transaction-level
// model of the sequencer plus a behavioural 256x8 RAM.
// Build option: MEM_ACCESS_VERIFY_EN shifts latencies and arms a corrupted write.
module tb_mem_access_ctrl;
  import mem_access_pkg::*;

`ifdef MEM_ACCESS_VERIFY_EN
  localparam int VER = 1;
`else
  localparam int VER = 0;
`endif

  localparam logic [1:0] M_NORM  = 2'd0;
  localparam logic [1:0] M_HOLD  = 2'd1;
  localparam logic [1:0] M_RST   = 2'd2;
  localparam logic [1:0] M_CORR  = 2'd3;

  typedef struct packed {
    op_e        op;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    logic       exp_err;
    logic [3:0] exp_lat;
    logic [1:0] mode;
  } row_t;

  localparam int NROW = 16;
  localparam row_t TBL [NROW] = '{
    '{OP_STORE, 8'h10, 8'h5A, 8'h00, 1'b0, 4'(2+VER), M_NORM},
    '{OP_LOAD,  8'h10, 8'h00, 8'h5A, 1'b0, 4'd2,      M_NORM},
    '{OP_STORE, 8'h20, 8'hF0, 8'h00, 1'b0, 4'(2+VER), M_NORM},
    '{OP_ADD,   8'h20, 8'h25, 8'hF0, 1'b0, 4'(3+VER), M_NORM},
    '{OP_LOAD,  8'h20, 8'h00, 8'h15, 1'b0, 4'd2,      M_NORM},
    '{OP_STORE, 8'hFF, 8'h33, 8'h00, 1'b0, 4'(2+VER), M_NORM},
    '{OP_SWAP,  8'hFF, 8'hCC, 8'h33, 1'b0, 4'(3+VER), M_NORM},
    '{OP_LOAD,  8'hFF, 8'h00, 8'hCC, 1'b0, 4'd2,      M_NORM},
    '{OP_LOAD,  8'h10, 8'h00, 8'h5A, 1'b0, 4'd2,      M_HOLD},
    '{OP_LOAD,  8'h20, 8'h00, 8'h15, 1'b0, 4'd2,      M_NORM},
    '{OP_STORE, 8'h30, 8'h01, 8'h00, 1'b0, 4'(2+VER), M_NORM},
    '{OP_ADD,   8'h30, 8'h7F, 8'h00, 1'b0, 4'(3+VER), M_RST},
    '{OP_LOAD,  8'h30, 8'h00, 8'h01, 1'b0, 4'd2,      M_NORM},
    '{OP_STORE, 8'h40, 8'hA5, 8'h00, 1'(VER), 4'(2+VER), M_CORR},
    '{OP_LOAD,  8'h40, 8'h00, 8'((VER != 0) ? 8'hA4 : 8'hA5), 1'b0, 4'd2, M_NORM},
    '{OP_LOAD,  8'h00, 8'h00, 8'h00, 1'b0, 4'd2,      M_NORM}
  };

  logic       clk;
  logic       rst;
  logic       ram_rw;
  logic [7:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;
  logic       busy;
  logic       corrupt_en;
  logic [7:0] corrupt_addr;

  logic [7:0] ram_mem   [256] = '{default: 8'h00};
  logic [7:0] model_mem [256] = '{default: 8'h00};

  int n_vec = 0;
  int n_mis = 0;
  int cyc   = 0;

  mem_access_ctrl_if #(.DW(8), .AW(8)) bus ();

  mem_access_ctrl #(.DW(8), .AW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .ram_rw    (ram_rw),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural RAM: async read, sync write, optional single-address corruption
  assign ram_rdata = ram_mem[ram_addr];
  always @(posedge clk) begin
    if (ram_rw) begin
      ram_mem[ram_addr] <= (corrupt_en && (ram_addr == corrupt_addr)) ?
                           (ram_wdata ^ 8'h01) : ram_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // model state (owned by the compare process)
  logic       pending = 1'b0;
  op_e        p_op;
  logic [7:0] p_addr;
  logic [7:0] p_wd;
  logic [7:0] p_rd;
  logic       p_err;
  int         p_idx;
  int         acc_cyc;
  int         wr_cyc;
  int         rsp_cyc;
  int         txn = 0;
  logic       exp_rw;
  logic       exp_valid;
  logic       corrupted;

  // compare process: sample mid-cycle, check every output against the model
  initial begin : compare
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_ram_rw",    32'(ram_rw),        32'd0);
        chk("rst_busy",      32'(busy),          32'd0);
        pending = 1'b0;
      end else begin
        exp_rw = pending && (cyc == wr_cyc);
        chk("ram_rw", 32'(ram_rw), 32'(exp_rw));
        if (exp_rw) begin
          chk("ram_addr",  32'(ram_addr),  32'(p_addr));
          chk("ram_wdata", 32'(ram_wdata), 32'(p_wd));
          corrupted = corrupt_en && (p_addr == corrupt_addr);
          model_mem[p_addr] = corrupted ? (p_wd ^ 8'h01) : p_wd;
          if (VER != 0) p_err = corrupted;
        end
        chk("req_ready", 32'(bus.req_ready), 32'(!pending));
        chk("busy",      32'(busy),          32'(pending));
        exp_valid = pending && (cyc >= rsp_cyc);
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_valid));
        if (exp_valid) begin
          chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(p_rd));
          chk("rsp_err",   32'(bus.rsp_err),   32'(p_err));
          if (cyc == rsp_cyc) begin
            chk("latency",   32'(cyc - acc_cyc),   32'(TBL[p_idx].exp_lat));
            chk("lit_rdata", 32'(bus.rsp_rdata),   32'(TBL[p_idx].exp_rdata));
            chk("lit_err",   32'(bus.rsp_err),     32'(TBL[p_idx].exp_err));
          end
          if (bus.rsp_ready) pending = 1'b0;
        end else if (!pending && bus.req_valid) begin
          p_idx   = (txn < NROW) ? txn : NROW - 1;
          txn++;
          pending = 1'b1;
          p_op    = op_e'(bus.req_op);
          p_addr  = bus.req_addr;
          p_err   = 1'b0;
          acc_cyc = cyc;
          p_rd    = (p_op == OP_STORE) ? 8'h00 : model_mem[p_addr];
          p_wd    = (p_op == OP_ADD) ? 8'(model_mem[p_addr] + bus.req_wdata) : bus.req_wdata;
          case (p_op)
            OP_LOAD:  begin wr_cyc = -1;      rsp_cyc = cyc + 2;       end
            OP_STORE: begin wr_cyc = cyc + 1; rsp_cyc = cyc + 2 + VER; end
            default:  begin wr_cyc = cyc + 2; rsp_cyc = cyc + 3 + VER; end
          endcase
        end
      end
    end
  end

  task automatic drive_req(input row_t r);
    bus.req_op    = r.op;
    bus.req_addr  = r.addr;
    bus.req_wdata = r.wdata;
    bus.req_valid = 1'b1;
  endtask

  task automatic do_req(input row_t r);
    drive_req(r);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        return;
      end
    end
    $display("FAIL req_timeout: request not accepted within 40 cycles");
    $fatal(1);
  endtask

  task automatic wait_valid();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) return;
    end
    $display("FAIL rsp_timeout: no rsp_valid within 40 cycles");
    $fatal(1);
  endtask

  task automatic wait_rsp();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.rsp_valid && bus.rsp_ready) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    $display("FAIL rsp_timeout: no response handshake within 40 cycles");
    $fatal(1);
  endtask

  // stimulus
  initial begin : stim
    int i;
    rst           = 1'b1;
    corrupt_en    = 1'b0;
    corrupt_addr  = 8'h00;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_addr  = 8'h00;
    bus.req_wdata = 8'h00;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    i = 0;
    while (i < NROW) begin
      case (TBL[i].mode)
        M_HOLD: begin
          bus.rsp_ready = 1'b0;
          do_req(TBL[i]);
          wait_valid();
          @(posedge clk);
          #1;
          drive_req(TBL[i+1]);
          repeat (4) @(posedge clk);
          #1 bus.rsp_ready = 1'b1;
          wait_rsp();
          do_req(TBL[i+1]);
          wait_rsp();
          i += 2;
        end
        M_RST: begin
          bus.rsp_ready = 1'b1;
          do_req(TBL[i]);
          @(posedge clk);
          #1 rst = 1'b1;
          @(posedge clk);
          #1 rst = 1'b0;
          @(posedge clk);
          #1;
          i += 1;
        end
        M_CORR: begin
          bus.rsp_ready = 1'b1;
          corrupt_addr  = TBL[i].addr;
          corrupt_en    = (VER != 0);
          do_req(TBL[i]);
          wait_rsp();
          corrupt_en    = 1'b0;
          i += 1;
        end
        default: begin
          bus.rsp_ready = 1'b1;
          do_req(TBL[i]);
          wait_rsp();
          i += 1;
        end
      endcase
    end
    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
